// File: rtl/stream_mux.sv
// stream_mux: selects one of INPUTS valid/ready streams, either by external addr or by
// round-robin rotation, and forwards it through a single registered output slot.
module stream_mux #(
    parameter int DATA_WIDTH = 32,
    parameter int INPUTS     = 4,
    localparam int ADDR_WIDTH = $clog2(INPUTS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] inputs [INPUTS-1:0],
    input  logic [INPUTS-1:0]     in_valid,
    output logic [INPUTS-1:0]     in_ready,
    input  logic                  mode,
    input  logic [ADDR_WIDTH-1:0] addr,
    output logic [DATA_WIDTH-1:0] out,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ADDR_WIDTH-1:0] out_src
);

    logic [DATA_WIDTH-1:0] out_r;
    logic                  out_valid_r;
    logic [ADDR_WIDTH-1:0] out_src_r;
    logic [ADDR_WIDTH-1:0] last_r;

    logic                  load_en_s;
    logic [INPUTS-1:0]     fixed_grant_s;
    logic [INPUTS-1:0]     rr_grant_s;
    logic [INPUTS-1:0]     grant_s;
    logic                  rr_found_s;
    int                    rr_idx_s;
    logic                  any_s;
    logic [ADDR_WIDTH-1:0] sel_s;
    logic [DATA_WIDTH-1:0] sel_data_s;

    // Gated by rst_n so no handshake can complete while reset is held.
    assign load_en_s = rst_n & (~out_valid_r | out_ready);

    // Fixed-mode grant; an addr at or beyond INPUTS matches no channel.
    always_comb begin
        fixed_grant_s = '0;
        for (int i = 0; i < INPUTS; i++) begin
            fixed_grant_s[i] = in_valid[i] & (addr == ADDR_WIDTH'(i));
        end
    end

    // Round-robin grant: first valid channel after last, wrapping around.
    always_comb begin
        rr_grant_s = '0;
        rr_found_s = 1'b0;
        rr_idx_s   = 0;
        for (int k = 1; k <= INPUTS; k++) begin
            rr_idx_s             = (int'(last_r) + k) % INPUTS;
            rr_grant_s[rr_idx_s] = in_valid[rr_idx_s] & ~rr_found_s;
            rr_found_s           = rr_found_s | in_valid[rr_idx_s];
        end
    end

    // One-hot grant to index and data via AND-OR reduction.
    always_comb begin
        grant_s    = mode ? rr_grant_s : fixed_grant_s;
        sel_s      = '0;
        sel_data_s = '0;
        for (int i = 0; i < INPUTS; i++) begin
            sel_s      = sel_s | ({ADDR_WIDTH{grant_s[i]}} & ADDR_WIDTH'(i));
            sel_data_s = sel_data_s | ({DATA_WIDTH{grant_s[i]}} & inputs[i]);
        end
    end

    assign any_s    = |grant_s;
    assign in_ready = load_en_s ? grant_s : '0;

    // Output slot and round-robin pointer; last moves only on round-robin transfers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_r       <= '0;
            out_valid_r <= 1'b0;
            out_src_r   <= '0;
            last_r      <= ADDR_WIDTH'(INPUTS - 1);
        end else if (load_en_s) begin
            if (any_s) begin
                out_r       <= sel_data_s;
                out_src_r   <= sel_s;
                out_valid_r <= 1'b1;
                if (mode) begin
                    last_r <= sel_s;
                end
            end else begin
                out_valid_r <= 1'b0;
            end
        end
    end

    assign out       = out_r;
    assign out_valid = out_valid_r;
    assign out_src   = out_src_r;

endmodule
